// File: rtl/psram_rd_arb.sv
// Two-requester round-robin read arbiter in front of a single-burst PSRAM controller.
// Owns the address phase, routes data-beat strobes to the granted requester, and abandons silent bursts.
module psram_rd_arb #(
    parameter int BURST_BEATS = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        psram_ready,

    input  logic [24:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic        m0_rvalid,

    input  logic [24:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic        m1_rvalid,

    output logic [24:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic        s_rvalid,

    output logic        grant_id,
    output logic        busy,
    output logic        err_stray,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [7:0]  LAST_BEAT  = 8'(BURST_BEATS - 1);
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;
    logic [7:0]  beat_cnt;
    logic [15:0] wdog;

    logic any_req;
    logic winner;

    // On a tie the requester that did not own the previous burst wins.
    assign any_req = m0_arvalid | m1_arvalid;
    assign winner  = (m0_arvalid & m1_arvalid) ? ~last_grant : m1_arvalid;

    // Handshake and beat routing are combinational so beats reach the owner with zero latency.
    assign m0_arready = (state == ADDR) & s_arready & ~grant_id;
    assign m1_arready = (state == ADDR) & s_arready &  grant_id;
    assign m0_rvalid  = (state == DATA) & s_rvalid  & ~grant_id;
    assign m1_rvalid  = (state == DATA) & s_rvalid  &  grant_id;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            s_araddr    <= '0;
            s_arvalid   <= 1'b0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            busy        <= 1'b0;
            err_stray   <= 1'b0;
            err_timeout <= 1'b0;
            beat_cnt    <= '0;
            wdog        <= '0;
        end else begin
            // NOTE: error flags default low every cycle so each assertion below is a single-cycle pulse.
            err_stray   <= 1'b0;
            err_timeout <= 1'b0;

            unique case (state)
                IDLE: begin
                    err_stray <= s_rvalid;
                    if (psram_ready && any_req) begin
                        state     <= ADDR;
                        grant_id  <= winner;
                        s_araddr  <= winner ? m1_araddr : m0_araddr;
                        s_arvalid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                ADDR: begin
                    if (s_arready) begin
                        state      <= DATA;
                        s_arvalid  <= 1'b0;
                        beat_cnt   <= '0;
                        wdog       <= '0;
                        last_grant <= grant_id;
                    end
                end

                DATA: begin
                    if (s_rvalid) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        wdog     <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        wdog <= wdog + 16'd1;
                        // Silent for TIMEOUT cycles: give the bus up so the other requester is not starved.
                        if (wdog == WDOG_LIMIT) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            err_timeout <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
